// File: rtl/alu_req_sequencer.sv
// Initiator-side sequencer for the registered ALU: issues requests, tracks them through the ALU
// latency, resolves branches and queues responses. Optional counters under ALU_SEQ_STATS_EN.
module alu_req_sequencer #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned RSP_DEPTH   = 4,
    parameter int unsigned TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_in1,
    input  logic [31:0]      req_in2,
    input  logic [2:0]       req_op,
    input  logic             req_is_branch,
    input  logic [2:0]       req_br_funct3,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic [31:0]      alu_in1,
    output logic [31:0]      alu_in2,
    output logic [2:0]       alu_op,
    input  logic [31:0]      alu_out,
    input  logic             zero,
    input  logic             less_than,
    input  logic             less_than_unsigned,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_taken,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_taken
);

    localparam int unsigned PtrW     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned FifoCntW = PtrW + 1;
    localparam int unsigned CntW     = PtrW + 2;
    localparam int unsigned FlW      = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    typedef struct packed {
        logic             valid;
        logic             is_branch;
        logic [2:0]       funct3;
        logic [TAG_W-1:0] tag;
    } pipe_t;

    typedef struct packed {
        logic [31:0]      result;
        logic             taken;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    state_e              state_q;
    logic [FlW-1:0]      flush_cnt_q;
    logic [31:0]         alu_in1_q, alu_in2_q;
    logic [2:0]          alu_op_q;
    // Entry 0 lines up with the alu_* registers; entry ALU_LATENCY lines up with alu_out.
    pipe_t               pipe_q [ALU_LATENCY+1];
    rsp_t                mem_q [RSP_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [FifoCntW-1:0] fifo_cnt_q;

    logic [CntW-1:0]     inflight_cnt;
    logic                accept, push, pop, flush_now, br_cond, tail_taken;
    pipe_t               tail;
    rsp_t                head;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i <= int'(ALU_LATENCY); i++) begin
            inflight_cnt = inflight_cnt + CntW'(pipe_q[i].valid);
        end
    end

    assign flush_now = flush && (state_q == StRun);
    assign req_ready = (state_q == StRun) && !flush &&
                       ((inflight_cnt + CntW'(fifo_cnt_q)) < CntW'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;

    assign tail = pipe_q[ALU_LATENCY];

    always_comb begin
        br_cond = 1'b0;
        case (tail.funct3)
            3'b000:  br_cond = zero;
            3'b001:  br_cond = !zero;
            3'b100:  br_cond = less_than;
            3'b101:  br_cond = !less_than;
            3'b110:  br_cond = less_than_unsigned;
            3'b111:  br_cond = !less_than_unsigned;
            default: br_cond = 1'b0;
        endcase
    end

    assign tail_taken = tail.is_branch && br_cond;
    assign push       = tail.valid && (state_q == StRun) && !flush;
    assign rsp_valid  = (fifo_cnt_q != '0);
    assign pop        = rsp_valid && rsp_ready;

    assign head       = mem_q[rd_ptr_q];
    assign rsp_result = rsp_valid ? head.result : '0;
    assign rsp_taken  = rsp_valid ? head.taken : 1'b0;
    assign rsp_tag    = rsp_valid ? head.tag : '0;

    assign alu_in1 = alu_in1_q;
    assign alu_in2 = alu_in2_q;
    assign alu_op  = alu_op_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{result: alu_out, taken: tail_taken, tag: tail.tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            flush_cnt_q <= '0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_op_q    <= 3'b000;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            for (int i = 0; i <= int'(ALU_LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                alu_in1_q <= req_in1;
                alu_in2_q <= req_in2;
                alu_op_q  <= req_is_branch ? 3'b001 : req_op;
            end

            pipe_q[0] <= '{valid: accept, is_branch: req_is_branch,
                           funct3: req_br_funct3, tag: req_tag};
            for (int i = 1; i <= int'(ALU_LATENCY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (flush_now || state_q == StFlush) begin
                for (int i = 0; i <= int'(ALU_LATENCY); i++) begin
                    pipe_q[i].valid <= 1'b0;
                end
            end

            if (flush_now) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                fifo_cnt_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
                if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + FifoCntW'(1);
                else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - FifoCntW'(1);
            end

            // FLUSH holds for ALU_LATENCY+1 cycles so the ALU drains anything already issued.
            case (state_q)
                StRun: begin
                    if (flush_now) begin
                        state_q     <= StFlush;
                        flush_cnt_q <= FlW'(ALU_LATENCY);
                    end
                end
                StFlush: begin
                    if (flush_cnt_q == '0 && inflight_cnt == '0) state_q <= StRun;
                    else if (flush_cnt_q != '0) flush_cnt_q <= flush_cnt_q - FlW'(1);
                end
                default: state_q <= StRun;
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [31:0] stat_issued_q, stat_taken_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_taken_q  <= '0;
        end else begin
            if (accept)               stat_issued_q <= stat_issued_q + 32'd1;
            if (push && tail_taken)   stat_taken_q  <= stat_taken_q + 32'd1;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_taken  = stat_taken_q;
`else
    assign stat_issued = '0;
    assign stat_taken  = '0;
`endif

    rsp_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && fifo_cnt_q == FifoCntW'(RSP_DEPTH)));

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Scoreboard bench for alu_req_sequencer with a behavioural single-cycle ALU in the loop.
module tb_alu_req_sequencer;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_is_branch, flush;
    logic [31:0] req_in1, req_in2, alu_in1, alu_in2, alu_out, rsp_result;
    logic [2:0]  req_op, req_br_funct3, alu_op;
    logic [3:0]  req_tag, rsp_tag;
    logic        zero, less_than, less_than_unsigned;
    logic        rsp_valid, rsp_ready, rsp_taken;
    logic [31:0] stat_issued, stat_taken;

    typedef struct packed {
        logic [31:0] r;
        logic        t;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    alu_req_sequencer #(.ALU_LATENCY(1), .RSP_DEPTH(4), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_op(req_op),
        .req_is_branch(req_is_branch), .req_br_funct3(req_br_funct3), .req_tag(req_tag),
        .flush(flush),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .zero(zero), .less_than(less_than),
        .less_than_unsigned(less_than_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_taken(rsp_taken), .rsp_tag(rsp_tag),
        .stat_issued(stat_issued), .stat_taken(stat_taken)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return a << b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // Registered ALU, one cycle of latency.
    always @(posedge clk) begin
        alu_out            <= alu_f(alu_in1, alu_in2, alu_op);
        zero               <= (alu_f(alu_in1, alu_in2, alu_op) == 32'd0);
        less_than          <= ($signed(alu_in1) < $signed(alu_in2));
        less_than_unsigned <= (alu_in1 < alu_in2);
    end

    // Response scoreboard: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_rsp result=%h tag=%0d, none expected", rsp_result,
                         rsp_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                vectors += 3;
                if (rsp_result !== e.r) begin
                    miscompares++;
                    $display("FAIL rsp_result tag=%0d got %h want %h", e.tag, rsp_result, e.r);
                end
                if (rsp_taken !== e.t) begin
                    miscompares++;
                    $display("FAIL rsp_taken tag=%0d got %b want %b", e.tag, rsp_taken, e.t);
                end
                if (rsp_tag !== e.tag) begin
                    miscompares++;
                    $display("FAIL rsp_tag got %0d want %0d", rsp_tag, e.tag);
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic br, input logic [2:0] f3, input logic [3:0] tag,
                        input logic [31:0] er, input logic et, output int waits);
        req_in1 = a; req_in2 = b; req_op = op; req_is_branch = br;
        req_br_funct3 = f3; req_tag = tag; req_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout tag=%0d got ready=0 want 1", tag);
        end else begin
            exp_q.push_back('{r: er, t: et, tag: tag});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_in1 = '0; req_in2 = '0; req_op = '0;
        req_is_branch = 1'b0; req_br_funct3 = '0; req_tag = '0; flush = 1'b0;
        rsp_ready = 1'b0;
        #12;
        vectors += 7;
        if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_op !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_alu got %h %h %b want 0 0 000", alu_in1, alu_in2, alu_op);
        end
        if (rsp_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
        end
        if (rsp_result !== 32'd0) begin
            miscompares++; $display("FAIL reset_rsp_result got %h want 0", rsp_result);
        end
        if (rsp_taken !== 1'b0) begin
            miscompares++; $display("FAIL reset_rsp_taken got %b want 0", rsp_taken);
        end
        if (rsp_tag !== 4'd0) begin
            miscompares++; $display("FAIL reset_rsp_tag got %0d want 0", rsp_tag);
        end
        if (stat_issued !== 32'd0 || stat_taken !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_stats got %0d %0d want 0 0", stat_issued, stat_taken);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_req_ready got %b want 1", req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        int w;
        rsp_ready = 1'b1;
        send(32'd10, 32'd20, 3'b000, 1'b0, 3'b000, 4'd3, 32'd30, 1'b0, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== (i == 2)) begin
                miscompares++;
                $display("FAIL add_latency cycle=%0d got %b want %b", i + 1, rsp_valid, i == 2);
            end
        end
        @(posedge clk); #1;
        wait_drain();
    endtask

    task automatic test_branch();
        logic [31:0] a [8] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'd7, 32'hFFFFFFFE,
                               32'hFFFFFFFE, 32'd7, 32'd7, 32'd7};
        logic [31:0] b [8] = '{32'd1, 32'd1, 32'd7, 32'd1, 32'd1, 32'd7, 32'd7, 32'd7};
        logic [2:0]  f [8] = '{3'b100, 3'b110, 3'b000, 3'b101, 3'b111, 3'b001, 3'b010,
                               3'b011};
        logic        t [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int w;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(a[i], b[i], 3'b000, 1'b1, f[i], 4'(i + 1), a[i] - b[i], t[i], w);
            vectors++;
            if (alu_op !== 3'b001) begin
                miscompares++;
                $display("FAIL branch_alu_op f3=%b got %b want 001", f[i], alu_op);
            end
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3] = '{32'hFFFF0000, 32'hFF00FF00, 32'h0000000F};
        logic [31:0] b [3] = '{32'h0000FFFF, 32'h00FF00FF, 32'd2};
        logic [2:0]  o [3] = '{3'b010, 3'b011, 3'b101};
        logic [31:0] r [3] = '{32'h00000000, 32'hFFFFFFFF, 32'h0000003C};
        int w;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(a[i], b[i], o[i], 1'b0, 3'b000, 4'(i + 4), r[i], 1'b0, w);
            vectors++;
            if (w != 0) begin
                miscompares++;
                $display("FAIL b2b_ready op=%0d got %0d stall cycles want 0", i, w);
            end
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int acc = 0;
        logic took;
        rsp_ready = 1'b0;
        req_is_branch = 1'b0; req_op = 3'b000; req_in2 = 32'd100;
        req_in1 = 32'd0; req_tag = 4'd0; req_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            took = req_valid && req_ready;
            if (took) begin
                exp_q.push_back('{r: 32'(idx * 3) + 32'd100, t: 1'b0, tag: 4'(idx)});
                acc++;
            end
            @(posedge clk); #1;
            if (took) begin
                idx++;
                if (idx == 6) req_valid = 1'b0;
                req_in1 = 32'(idx * 3);
                req_tag = 4'(idx);
            end
        end
        @(negedge clk);
        vectors += 2;
        if (acc != 4) begin
            miscompares++; $display("FAIL bp_accepted got %0d want 4", acc);
        end
        if (req_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp_req_ready got %b want 0", req_ready);
        end
        for (int c = 0; c < 2; c++) begin
            if (c == 1) @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_result !== exp_q[0].r) begin
                miscompares++;
                $display("FAIL bp_hold got v=%b %h want v=1 %h", rsp_valid, rsp_result,
                         exp_q[0].r);
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_ready_return got %b want 1", req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int w;
        rsp_ready = 1'b0;
        send(32'd1, 32'd2, 3'b000, 1'b0, 3'b000, 4'd10, 32'd3, 1'b0, w);
        send(32'd3, 32'd4, 3'b000, 1'b0, 3'b000, 4'd11, 32'd7, 1'b0, w);
        send(32'd5, 32'd6, 3'b000, 1'b0, 3'b000, 4'd12, 32'd11, 1'b0, w);
        @(posedge clk); #1;
        // Two responses queued, one still in the ALU; a request rides along with the flush.
        flush = 1'b1;
        req_in1 = 32'd5; req_in2 = 32'd5; req_op = 3'b000; req_is_branch = 1'b0;
        req_tag = 4'd15; req_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++; $display("FAIL flush_same_cycle_ready got %b want 0", req_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors += 2;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_rsp_valid cycle=%0d got %b want 0", i + 1, rsp_valid);
            end
            if (req_ready !== (i == 2)) begin
                miscompares++;
                $display("FAIL flush_req_ready cycle=%0d got %b want %b", i + 1, req_ready,
                         i == 2);
            end
        end
        @(posedge clk); #1;
        send(32'd1, 32'd1, 3'b000, 1'b0, 3'b000, 4'd9, 32'd2, 1'b0, w);
        wait_drain();
    endtask

    task automatic test_reset_midop();
        int w;
        rsp_ready = 1'b1;
        send(32'd10, 32'd20, 3'b000, 1'b0, 3'b000, 4'd7, 32'd30, 1'b0, w);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (alu_in1 !== 32'd0 || alu_op !== 3'd0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midop_reset got in1=%h op=%b v=%b want 0 000 0", alu_in1, alu_op,
                     rsp_valid);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midop_dropped cycle=%0d got %b want 0", i, rsp_valid);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stats();
        int w;
        rsp_ready = 1'b1;
        send(32'd1, 32'd2, 3'b000, 1'b0, 3'b000, 4'd1, 32'd3, 1'b0, w);
        send(32'd4, 32'd4, 3'b000, 1'b1, 3'b000, 4'd2, 32'd0, 1'b1, w);
        send(32'd4, 32'd4, 3'b000, 1'b1, 3'b001, 4'd3, 32'd0, 1'b0, w);
        send(32'd1, 32'd2, 3'b000, 1'b1, 3'b110, 4'd4, 32'hFFFFFFFF, 1'b1, w);
        send(32'hF0, 32'h0F, 3'b011, 1'b0, 3'b000, 4'd5, 32'hFF, 1'b0, w);
        wait_drain();
        vectors += 2;
`ifdef ALU_SEQ_STATS_EN
        if (stat_issued !== 32'd5) begin
            miscompares++; $display("FAIL stat_issued got %0d want 5", stat_issued);
        end
        if (stat_taken !== 32'd2) begin
            miscompares++; $display("FAIL stat_taken got %0d want 2", stat_taken);
        end
`else
        if (stat_issued !== 32'd0) begin
            miscompares++; $display("FAIL stat_issued got %0d want 0", stat_issued);
        end
        if (stat_taken !== 32'd0) begin
            miscompares++; $display("FAIL stat_taken got %0d want 0", stat_taken);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_req_sequencer.md
Name: alu_req_sequencer

Overview:
- Initiator-side controller for the registered `alu` block.
- Accepts operation requests from the issue stage over a valid/ready handshake and drives `alu_in1`/`alu_in2`/`alu_op`.
- Tracks in-flight operations through the ALU's fixed latency and captures `alu_out` plus flags into a response FIFO.
- Resolves RISC-V branch conditions from `zero`/`less_than`/`less_than_unsigned`, returning result, taken bit and tag downstream with backpressure.

Parameters:
- ALU_LATENCY, 1: clock edges from `alu_*` inputs being stable to `alu_out`/flags valid.
- RSP_DEPTH, 4: response FIFO entries; power of two, at least ALU_LATENCY+2.
- TAG_W, 4: request tag width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid&ready at rising edge
- req_in1  in  32  operand 1
- req_in2  in  32  operand 2
- req_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLL
- req_is_branch  in  1  request is a branch compare
- req_br_funct3  in  3  RISC-V branch funct3
- req_tag  in  TAG_W  opaque tag, returned with response
- flush  in  1  single-cycle pulse: discard all outstanding work
- alu_in1  out  32  to ALU
- alu_in2  out  32  to ALU
- alu_op  out  3  to ALU
- alu_out  in  32  from ALU
- zero  in  1  from ALU
- less_than  in  1  from ALU
- less_than_unsigned  in  1  from ALU
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  ALU result
- rsp_taken  out  1  branch taken; 0 for non-branch
- rsp_tag  out  TAG_W  tag of request
- stat_issued  out  32  issued-op counter; 0 when feature is compiled out
- stat_taken  out  32  taken-branch counter; 0 when feature is compiled out

Behaviour:
- Reset: asynchronous assert and synchronous-release usage. Applies regardless of state; a reset mid-operation drops all in-flight work.
  - `alu_in1` = 0, `alu_in2` = 0, `alu_op` = 000.
  - `rsp_valid` = 0, `rsp_result` = 0, `rsp_taken` = 0, `rsp_tag` = 0.
  - FIFO empty, in-flight pipe empty, state = RUN, stats = 0.
- States: RUN and FLUSH.
  - RUN: `req_ready` = (inflight_cnt + fifo_cnt < RSP_DEPTH), combinational.
  - FLUSH: `req_ready` = 0.
- Issue: on accept at edge E0, register the ALU inputs. `alu_op` is forced to 001 (SUB) when `req_is_branch` = 1. With no accept, `alu_*` hold their last values.
- Tracking: a shift pipe of depth ALU_LATENCY carries {valid, is_branch, funct3, tag}.
  - At edge E0+ALU_LATENCY+1, sample `alu_out`/flags and push them into the FIFO.
  - `rsp_valid` rises after that edge when the FIFO was empty.
  - Accept-to-`rsp_valid` = ALU_LATENCY+1 cycles.
- Branch resolve (only when `req_is_branch` = 1):
  - 000 BEQ = `zero`
  - 001 BNE = !`zero`
  - 100 BLT = `less_than`
  - 101 BGE = !`less_than`
  - 110 BLTU = `less_than_unsigned`
  - 111 BGEU = !`less_than_unsigned`
  - 010/011 → `rsp_taken` = 0
- Response FIFO: first-word-fallthrough; pop on `rsp_valid` & `rsp_ready`.
  - Simultaneous push and pop is legal at any occupancy, and the count is unchanged.
  - The credit rule guarantees the FIFO never overflows. Overflow is an assertion failure.
- Throughput: 1 op/cycle sustained with `rsp_ready` held at 1 and RSP_DEPTH ≥ ALU_LATENCY+2.
- Backpressure: `rsp_ready` = 0 stalls the FIFO; `req_ready` falls once credits are exhausted. `rsp_*` are held stable while `rsp_valid` & !`rsp_ready`.
- Flush:
  - In RUN, a `flush` pulse clears the FIFO at that edge (`rsp_valid` = 0 next cycle) and moves to FLUSH.
  - FLUSH marks all in-flight pipe entries invalid and suppresses pushes.
  - FLUSH returns to RUN when the in-flight pipe is empty, after ALU_LATENCY+1 cycles.
  - A request presented in the same cycle as `flush` is not accepted.
  - `flush` while already in FLUSH is ignored.
- Counters wrap modulo 2^32.

Optional Feature:
- Macro ALU_SEQ_STATS_EN.
- Defined: `stat_issued` increments on every accepted request; `stat_taken` increments on every FIFO push with taken = 1. Both reset to 0 and are unaffected by `flush`.
- Undefined: no counter flops; both stat ports are tied to 0.

Test Plan:
- Reset, then ADD 10+20, tag 3, `rsp_ready` = 1 → `rsp_valid` 2 cycles after accept, `rsp_result` = 30, `rsp_taken` = 0, `rsp_tag` = 3.
- Branch BLT in1 = 0xFFFFFFFE, in2 = 1 → `alu_op` driven 001, `rsp_taken` = 1; same operands with BLTU → `rsp_taken` = 0; BEQ 7,7 → `rsp_taken` = 1.
- Back-to-back AND 0xFFFF0000&0x0000FFFF, OR 0xFF00FF00|0x00FF00FF, SLL 0xF<<2 → results 0x00000000, 0xFFFFFFFF, 0x0000003C in order; `req_ready` stays 1.
- Hold `rsp_ready` = 0 while streaming 6 requests → exactly 4 accepted, then `req_ready` = 0. Release → 4 responses drain in order and `req_ready` returns.
- `flush` with 2 queued plus 1 in flight → `rsp_valid` = 0 next cycle, no stale response appears, `req_ready` = 0 for 2 cycles, new ADD 1+1 returns 2.
- With ALU_SEQ_STATS_EN, 5 ops including 2 taken branches → `stat_issued` = 5, `stat_taken` = 2. Without the macro, both read 0.
